// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: special register
// addresses and the requester index encoding used for the grant vector.
package rf_wb_arbiter_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_XP   = 5'd26;
    localparam int         NUM_REQ  = 3;

    typedef enum logic [1:0] {
        REQ_EXC = 2'd0,
        REQ_MEM = 2'd1,
        REQ_ALU = 2'd2
    } req_idx_e;

endpackage

// File: rtl/rf_wb_arbiter_prio_sel.sv
// Combinational priority selector: exc first, then mem over alu unless the
// starve logic has promoted alu.
module rf_wb_prio_sel
    import rf_wb_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               promote_alu,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid[REQ_EXC]) begin
            grant[REQ_EXC] = 1'b1;
        end else if (promote_alu && valid[REQ_ALU]) begin
            grant[REQ_ALU] = 1'b1;
        end else if (valid[REQ_MEM]) begin
            grant[REQ_MEM] = 1'b1;
        end else if (valid[REQ_ALU]) begin
            grant[REQ_ALU] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between exception, load and ALU
// write-back, with one registered output stage and a retired-write counter.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             exc_valid,
    input  logic [4:0]       exc_addr,
    input  logic [31:0]      exc_data,
    output logic             exc_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_addr,
    input  logic [31:0]      mem_data,
    output logic             mem_ready,
    input  logic             alu_valid,
    input  logic [4:0]       alu_addr,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    output logic             rf_wr,
    output logic [4:0]       rf_addr,
    output logic [31:0]      rf_data,
    output logic [CNT_W-1:0] wr_count
);

    localparam int unsigned         ST_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [ST_W-1:0]     STARVE_MAX = ST_W'(STARVE_LIMIT);

    // Handshake: a requester holds valid/addr/data stable until it sees ready;
    // the transfer happens on the rising edge where valid && ready, and ready
    // is a pure combinational function of the valids and the starve count.
    logic [ST_W-1:0]    starve;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic [4:0]         sel_addr;
    logic [31:0]        sel_data;

    rf_wb_prio_sel u_prio_sel (
        .valid       ({alu_valid, mem_valid, exc_valid}),
        .promote_alu (starve == STARVE_MAX),
        .grant       (grant)
    );

    assign exc_ready = grant[REQ_EXC];
    assign mem_ready = grant[REQ_MEM];
    assign alu_ready = grant[REQ_ALU];
    assign any_grant = |grant;

    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (grant[REQ_EXC]) begin
            sel_addr = exc_addr;
            sel_data = exc_data;
        end else if (grant[REQ_MEM]) begin
            sel_addr = mem_addr;
            sel_data = mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve <= '0;
        end else if (grant[REQ_ALU]) begin
            starve <= '0;
        end else if (alu_valid && starve != STARVE_MAX) begin
            starve <= starve + 1'b1;
        end
    end

    // Writes to r0 are consumed here so the register file never sees them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_wr    <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            wr_count <= '0;
        end else if (any_grant) begin
            rf_wr   <= (sel_addr != REG_ZERO);
            rf_addr <= sel_addr;
            rf_data <= sel_data;
            if (sel_addr != REG_ZERO) begin
                wr_count <= wr_count + 1'b1;
            end
        end else begin
            rf_wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed cases plus randomized traffic
// scored against a queue-based reference of the arbitration rules.
module tb_rf_wb_arbiter;

    localparam int STARVE_LIMIT = 3;
    localparam int CNT_W        = 16;
    localparam int SMALL_W      = 4;
    localparam int W            = 1 + 5 + 32 + CNT_W + SMALL_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               exc_valid = 1'b0, mem_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0]         exc_addr = '0, mem_addr = '0, alu_addr = '0;
    logic [31:0]        exc_data = '0, mem_data = '0, alu_data = '0;
    logic               exc_ready, mem_ready, alu_ready;
    logic               rf_wr;
    logic [4:0]         rf_addr;
    logic [31:0]        rf_data;
    logic [CNT_W-1:0]   wr_count;
    logic               s_exc_ready, s_mem_ready, s_alu_ready, s_rf_wr;
    logic [4:0]         s_rf_addr;
    logic [31:0]        s_rf_data;
    logic [SMALL_W-1:0] s_wr_count;

    rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .reset(reset), .clk(clk),
        .exc_valid(exc_valid), .exc_addr(exc_addr), .exc_data(exc_data), .exc_ready(exc_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .wr_count(wr_count)
    );

    // Narrow-counter copy so the counter wrap is reached in a short run.
    rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(SMALL_W)) dut_small (
        .reset(reset), .clk(clk),
        .exc_valid(exc_valid), .exc_addr(exc_addr), .exc_data(exc_data), .exc_ready(s_exc_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(s_mem_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(s_alu_ready),
        .rf_wr(s_rf_wr), .rf_addr(s_rf_addr), .rf_data(s_rf_data), .wr_count(s_wr_count)
    );

    always #5 clk = ~clk;

    // Pending requests per requester (0=exc, 1=mem, 2=alu) and reference state.
    bit          pend_v[3];
    logic [4:0]  p_addr[3];
    logic [31:0] p_data[3];
    int          starve_m;
    int          cnt_m;
    int          cnt_s_m;
    int          wraps_s;
    logic [W-1:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          gen_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        starve_m = 0;
        cnt_m    = 0;
        cnt_s_m  = 0;
        for (int i = 0; i < 3; i++) pend_v[i] = 1'b0;
    endtask

    task automatic gen_new();
        for (int i = 0; i < 3; i++) begin
            if (!pend_v[i] && $urandom_range(0, 99) < 60) begin
                pend_v[i] = 1'b1;
                if (i == 0)
                    p_addr[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd26;
                else
                    p_addr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p_data[i] = $urandom;
            end
        end
    endtask

    // One clock of stimulus: present pending requests, predict the winner,
    // check the readies and queue the expected output-stage contents.
    task automatic step();
        int   win;
        logic wr;
        @(negedge clk);
        if (gen_en) gen_new();
        exc_valid = pend_v[0]; exc_addr = p_addr[0]; exc_data = p_data[0];
        mem_valid = pend_v[1]; mem_addr = p_addr[1]; mem_data = p_data[1];
        alu_valid = pend_v[2]; alu_addr = p_addr[2]; alu_data = p_data[2];
        #1;
        win = -1;
        if (pend_v[0]) win = 0;
        else if (pend_v[1] && pend_v[2]) win = (starve_m == STARVE_LIMIT) ? 2 : 1;
        else if (pend_v[1]) win = 1;
        else if (pend_v[2]) win = 2;
        chk("exc_ready", 64'(exc_ready), 64'(win == 0));
        chk("mem_ready", 64'(mem_ready), 64'(win == 1));
        chk("alu_ready", 64'(alu_ready), 64'(win == 2));
        if (win == 2) starve_m = 0;
        else if (pend_v[2] && starve_m < STARVE_LIMIT) starve_m++;
        wr = 1'b0;
        if (win >= 0) begin
            wr = (p_addr[win] != 5'd0);
            if (wr) begin
                cnt_m   = (cnt_m + 1) % (1 << CNT_W);
                cnt_s_m = (cnt_s_m + 1) % (1 << SMALL_W);
                if (cnt_s_m == 0) wraps_s++;
            end
            pend_v[win] = 1'b0;
        end
        if (mon_en)
            exp_q.push_back({wr, (win >= 0) ? p_addr[win] : 5'd0, (win >= 0) ? p_data[win] : 32'd0,
                             CNT_W'(cnt_m), SMALL_W'(cnt_s_m)});
    endtask

    // Monitor: every edge with a queued expectation is compared after it settles.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_wr", 64'(rf_wr), 64'(e[W-1]));
                if (e[W-1]) begin
                    chk("rf_addr", 64'(rf_addr), 64'(e[W-2 -: 5]));
                    chk("rf_data", 64'(rf_data), 64'(e[W-7 -: 32]));
                end
                chk("wr_count", 64'(wr_count), 64'(e[SMALL_W +: CNT_W]));
                chk("wr_count_wrap", 64'(s_wr_count), 64'(e[SMALL_W-1:0]));
            end
        end
    end

    initial begin
        wraps_s = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rf_wr", 64'(rf_wr), 64'd0);
        chk("reset_rf_addr", 64'(rf_addr), 64'd0);
        chk("reset_rf_data", 64'(rf_data), 64'd0);
        chk("reset_wr_count", 64'(wr_count), 64'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        // Single ALU write.
        pend_v[2] = 1'b1; p_addr[2] = 5'd5; p_data[2] = 32'h1234;
        step();
        chk("single_alu_ready", 64'(alu_ready), 64'd1);
        @(posedge clk); #2;
        chk("single_rf_wr", 64'(rf_wr), 64'd1);
        chk("single_rf_addr", 64'(rf_addr), 64'd5);
        chk("single_rf_data", 64'(rf_data), 64'h1234);
        chk("single_wr_count", 64'(wr_count), 64'd1);

        // ALU write to r0 is accepted but never reaches the register file.
        pend_v[2] = 1'b1; p_addr[2] = 5'd0; p_data[2] = 32'hFFFF_FFFF;
        step();
        chk("r0_alu_ready", 64'(alu_ready), 64'd1);
        @(posedge clk); #2;
        chk("r0_rf_wr", 64'(rf_wr), 64'd0);
        chk("r0_wr_count", 64'(wr_count), 64'd1);

        // mem and alu both valid continuously: MEM,MEM,MEM,ALU repeating.
        for (int i = 0; i < 8; i++) begin
            if (!pend_v[1]) begin pend_v[1] = 1'b1; p_addr[1] = 5'(8 + i); p_data[1] = $urandom; end
            if (!pend_v[2]) begin pend_v[2] = 1'b1; p_addr[2] = 5'(16 + i); p_data[2] = $urandom; end
            step();
            chk("order_alu", 64'(alu_ready), 64'(i % 4 == 3));
            chk("order_mem", 64'(mem_ready), 64'(i % 4 != 3));
        end

        // All three valid together: exc first, then mem.
        pend_v[0] = 1'b1; p_addr[0] = 5'd26; p_data[0] = 32'hBFC0_0004;
        if (!pend_v[1]) begin pend_v[1] = 1'b1; p_addr[1] = 5'd3; p_data[1] = 32'h3333; end
        if (!pend_v[2]) begin pend_v[2] = 1'b1; p_addr[2] = 5'd4; p_data[2] = 32'h4444; end
        step();
        chk("all3_exc_ready", 64'(exc_ready), 64'd1);
        @(posedge clk); #2;
        chk("all3_rf_addr", 64'(rf_addr), 64'd26);
        step();
        chk("all3_then_mem", 64'(mem_ready), 64'd1);

        // Randomized traffic.
        gen_en = 1'b1;
        repeat (400) step();
        gen_en = 1'b0;
        repeat (10) step();

        // Asynchronous reset while a write is staged.
        pend_v[2] = 1'b1; p_addr[2] = 5'd7; p_data[2] = 32'hA5A5_A5A5;
        step();
        @(posedge clk); #3;
        chk("staged_rf_wr", 64'(rf_wr), 64'd1);
        mon_en = 1'b0;
        exp_q.delete();
        exc_valid = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rf_wr", 64'(rf_wr), 64'd0);
        chk("async_rf_addr", 64'(rf_addr), 64'd0);
        chk("async_rf_data", 64'(rf_data), 64'd0);
        chk("async_wr_count", 64'(wr_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;

        gen_en = 1'b1;
        repeat (300) step();
        gen_en = 1'b0;
        repeat (10) step();
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        if (wraps_s == 0) $display("note: narrow counter never wrapped");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
